// File: rtl/mips_mem_pkg.sv
// Shared memory-access types for the MIPS memory stage.
// Access sizes, access-unit FSM states and lane widths.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_size_t;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      DATA,
      WRITE,
      RESP
   } mau_state_t;

   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;
   localparam int WORD_W = 32;

endpackage

// File: rtl/mem_access_unit_if.sv
// Core-side request/response bundle of the memory access unit.
// master = core memory stage, slave = mem_access_unit.
interface mem_access_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_error;
   logic [31:0] resp_rdata;

   modport master (
      output req_valid, req_write, req_size,
      output req_signed, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_error,
      input  resp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_size,
      input  req_signed, req_addr, req_wdata,
      output req_ready, resp_valid, resp_error,
      output resp_rdata
   );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: load extract/extend,
// sub-word store merge and alignment check.
// Ports: word (RAM word), wdata (store data), off (addr[1:0]),
//   size, sgn -> rdata (extended), merged (new word), misaligned.
module mem_lane_align
   import mips_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        sgn,
   output logic [31:0] rdata,
   output logic [31:0] merged,
   output logic        misaligned
);

   logic [BYTE_W-1:0] byte_v;
   logic [HALF_W-1:0] half_v;

   always_comb begin
      byte_v     = word[{off, 3'b000} +: BYTE_W];
      half_v     = off[1] ? word[31:16] : word[15:0];
      rdata      = word;
      merged     = word;
      misaligned = 1'b0;
      case (size)
         MEM_BYTE: begin
            rdata = {{(WORD_W-BYTE_W){sgn & byte_v[BYTE_W-1]}},
                     byte_v};
            merged[{off, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
         end
         MEM_HALF: begin
            rdata = {{(WORD_W-HALF_W){sgn & half_v[HALF_W-1]}},
                     half_v};
            merged[{off[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
            misaligned = off[0];
         end
         MEM_WORD: begin
            merged     = wdata;
            misaligned = |off;
         end
         default: misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the core memory stage and word RAM.
// Ports: clock, reset_n (async, active-low); bus (core req/resp,
//   slave side); ram_write_enable/ram_address/ram_in/ram_out to RAM.
module mem_access_unit
   import mips_mem_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   mem_access_unit_if.slave  bus,
   output logic              ram_write_enable,
   output logic [31:0]       ram_address,
   output logic [31:0]       ram_in,
   input  logic [31:0]       ram_out
);

   mau_state_t  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic        write_q, write_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] wword_q, wword_d;
   logic [31:0] rdata_q, rdata_d;
   logic        error_q, error_d;

   logic [1:0]  off_s;
   logic [1:0]  size_s;
   logic [31:0] ext_rdata;
   logic [31:0] merged;
   logic        mis;
   logic        ram_active;

   // Alignment is judged on the live request while idle,
   // on the latched access afterwards.
   assign off_s  = (state_q == IDLE) ? bus.req_addr[1:0]
                                     : addr_q[1:0];
   assign size_s = (state_q == IDLE) ? bus.req_size : size_q;

   mem_lane_align u_align (
      .word       (ram_out),
      .wdata      (wdata_q),
      .off        (off_s),
      .size       (size_s),
      .sgn        (signed_q),
      .rdata      (ext_rdata),
      .merged     (merged),
      .misaligned (mis)
   );

   assign ram_active = (state_q == READ) || (state_q == DATA) ||
                       (state_q == WRITE);

   assign bus.req_ready    = (state_q == IDLE);
   assign bus.resp_valid   = (state_q == RESP);
   assign bus.resp_error   = (state_q == RESP) && error_q;
   assign bus.resp_rdata   = (state_q == RESP) ? rdata_q : 32'h0;
   assign ram_write_enable = (state_q == WRITE);
   assign ram_address      = ram_active ? {addr_q[31:2], 2'b00}
                                        : 32'h0;
   assign ram_in           = (state_q == WRITE) ? wword_q : 32'h0;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      size_d   = size_q;
      signed_d = signed_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      wword_d  = wword_q;
      rdata_d  = rdata_q;
      error_d  = error_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d   = bus.req_addr;
               size_d   = bus.req_size;
               signed_d = bus.req_signed;
               write_d  = bus.req_write;
               wdata_d  = bus.req_wdata;
               wword_d  = bus.req_wdata;
               rdata_d  = 32'h0;
               error_d  = 1'b0;
               if (mis) begin
                  error_d = 1'b1;
                  state_d = RESP;
               end else if (bus.req_write &&
                            bus.req_size == MEM_WORD) begin
                  state_d = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: state_d = DATA;
         DATA: begin
            if (write_q) begin
               wword_d = merged;
               state_d = WRITE;
            end else begin
               rdata_d = ext_rdata;
               state_d = RESP;
            end
         end
         WRITE: state_d = RESP;
         RESP:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         addr_q   <= 32'h0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         write_q  <= 1'b0;
         wdata_q  <= 32'h0;
         wword_q  <= 32'h0;
         rdata_q  <= 32'h0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         wword_q  <= wword_d;
         rdata_q  <= rdata_d;
         error_q  <= error_d;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a word RAM model.
// Table-driven vectors, scoreboard queue, reset and b2b sequences.
module tb_mem_access_unit;
   import mips_mem_pkg::*;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        ram_write_enable;
   logic [31:0] ram_address;
   logic [31:0] ram_in;
   logic [31:0] ram_out;

   mem_access_unit_if bus();

   mem_access_unit dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .bus              (bus),
      .ram_write_enable (ram_write_enable),
      .ram_address      (ram_address),
      .ram_in           (ram_in),
      .ram_out          (ram_out)
   );

   always #5 clock = ~clock;

   logic [31:0] mem [0:15];
   logic        bd_we = 1'b0;
   logic [3:0]  bd_idx = 4'h0;
   logic [31:0] bd_data = 32'h0;
   int          we_cnt = 0;
   logic [31:0] we_addr = 32'h0;
   int          cyc = 0;

   exp_t exp_q[$];
   int   acc_q[$];
   int   acc_log[$];
   int   resp_log[$];
   int   n_chk = 0;
   int   n_fail = 0;
   logic prev_resp = 1'b0;

   // RAM model: registered read, write on the edge leaving WRITE
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (bd_we) begin
         mem[bd_idx] <= bd_data;
      end else if (ram_write_enable) begin
         mem[ram_address[5:2]] <= ram_in;
         we_cnt  <= we_cnt + 1;
         we_addr <= ram_address;
      end
      ram_out <= mem[ram_address[5:2]];
   end

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      exp_t e;
      int   a;
      if (reset_n && bus.req_valid && bus.req_ready) begin
         acc_q.push_back(cyc + 1);
         acc_log.push_back(cyc + 1);
      end
      if (bus.resp_valid) begin
         check("resp_not_back2back", {31'h0, prev_resp}, 32'h0);
         check("resp_ram_addr", ram_address, 32'h0);
         check("resp_ram_we", {31'h0, ram_write_enable}, 32'h0);
         if (exp_q.size() == 0) begin
            check("unexpected_resp", 32'h1, 32'h0);
         end else begin
            e = exp_q.pop_front();
            a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
            check("resp_rdata", bus.resp_rdata, e.rdata);
            check("resp_error", {31'h0, bus.resp_error},
                  {31'h0, e.err});
            check("resp_latency", cyc - a + 1, e.lat);
         end
         resp_log.push_back(cyc);
      end
      prev_resp = bus.resp_valid;
   end

   task automatic idle_req();
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'($urandom);
      bus.req_size   = 2'($urandom);
      bus.req_signed = 1'($urandom);
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
   endtask

   task automatic drive(input vec_t v);
      bus.req_valid  = 1'b1;
      bus.req_write  = v.wr;
      bus.req_size   = v.size;
      bus.req_signed = v.sgn;
      bus.req_addr   = v.addr;
      bus.req_wdata  = v.wdata;
   endtask

   task automatic wait_accept();
      int t = 0;
      do begin
         @(negedge clock);
         t++;
      end while (!bus.req_ready && t < 30);
      check("accept", {31'h0, bus.req_ready}, 32'h1);
      @(posedge clock);
      #1;
   endtask

   task automatic wait_done();
      int t = 0;
      while (exp_q.size() != 0 && t < 30) begin
         @(negedge clock);
         t++;
      end
      check("resp_timeout", exp_q.size(), 32'h0);
      if (exp_q.size() != 0) begin
         exp_q.delete();
         acc_q.delete();
      end
      @(posedge clock);
      #1;
   endtask

   task automatic push_exp(input vec_t v);
      exp_t e;
      e.rdata = v.exp_rdata;
      e.err   = v.exp_err;
      e.lat   = v.exp_lat;
      exp_q.push_back(e);
   endtask

   task automatic run_vec(input vec_t v);
      int  wc;
      logic wr_ok;
      wc    = we_cnt;
      wr_ok = v.wr && !v.exp_err;
      push_exp(v);
      drive(v);
      wait_accept();
      idle_req();
      wait_done();
      check("we_count", we_cnt - wc, wr_ok ? 32'h1 : 32'h0);
      if (wr_ok)
         check("we_addr", we_addr, {v.addr[31:2], 2'b00});
   endtask

   task automatic bd_write(input int idx, input logic [31:0] d);
      bd_we   = 1'b1;
      bd_idx  = idx[3:0];
      bd_data = d;
      @(posedge clock);
      #1;
      bd_we = 1'b0;
   endtask

   task automatic check_reset(input string p);
      check({p, "_ready"}, {31'h0, bus.req_ready}, 32'h1);
      check({p, "_valid"}, {31'h0, bus.resp_valid}, 32'h0);
      check({p, "_error"}, {31'h0, bus.resp_error}, 32'h0);
      check({p, "_rdata"}, bus.resp_rdata, 32'h0);
      check({p, "_we"}, {31'h0, ram_write_enable}, 32'h0);
      check({p, "_addr"}, ram_address, 32'h0);
      check({p, "_in"}, ram_in, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [16];
      vec_t bv [3];
      vec_t v;
      int   wc, ab, rb;

      tbl[0]  = '{1, 2'b10, 0, 32'h4, 32'hDEADBEEF, 32'h0, 0, 2};
      tbl[1]  = '{0, 2'b10, 0, 32'h4, 32'h0, 32'hDEADBEEF, 0, 3};
      tbl[2]  = '{0, 2'b00, 1, 32'h8, 32'h0, 32'hFFFFFFA5, 0, 3};
      tbl[3]  = '{0, 2'b00, 0, 32'hB, 32'h0, 32'h00000080, 0, 3};
      tbl[4]  = '{0, 2'b01, 1, 32'hA, 32'h0, 32'hFFFF8070, 0, 3};
      tbl[5]  = '{0, 2'b01, 0, 32'h8, 32'h0, 32'h0000F0A5, 0, 3};
      tbl[6]  = '{0, 2'b00, 1, 32'h9, 32'h0, 32'hFFFFFFF0, 0, 3};
      tbl[7]  = '{0, 2'b00, 1, 32'hA, 32'h0, 32'h00000070, 0, 3};
      tbl[8]  = '{1, 2'b00, 0, 32'h1, 32'hFFFFFFAB, 32'h0, 0, 4};
      tbl[9]  = '{0, 2'b10, 0, 32'h0, 32'h0, 32'h1122AB44, 0, 3};
      tbl[10] = '{1, 2'b01, 0, 32'h2, 32'h1234CDEF, 32'h0, 0, 4};
      tbl[11] = '{0, 2'b10, 0, 32'h0, 32'h0, 32'hCDEFAB44, 0, 3};
      tbl[12] = '{0, 2'b01, 1, 32'h3, 32'h0, 32'h0, 1, 1};
      tbl[13] = '{1, 2'b10, 0, 32'h6, 32'h12345678, 32'h0, 1, 1};
      tbl[14] = '{0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1, 1};
      tbl[15] = '{1, 2'b11, 0, 32'h4, 32'h0BADF00D, 32'h0, 1, 1};

      bv[0] = '{0, 2'b00, 1, 32'h8, 32'h0, 32'hFFFFFFA5, 0, 3};
      bv[1] = '{0, 2'b01, 0, 32'hA, 32'h0, 32'h00008070, 0, 3};
      bv[2] = '{0, 2'b10, 0, 32'h8, 32'h0, 32'h8070F0A5, 0, 3};

      idle_req();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_reset("reset");
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      bd_write(2, 32'h8070F0A5);
      bd_write(0, 32'h11223344);

      for (int i = 0; i < 16; i++)
         run_vec(tbl[i]);

      check("mem_word0", mem[0], 32'hCDEFAB44);
      check("mem_word1", mem[1], 32'hDEADBEEF);

      // held req_valid across three loads
      ab = acc_log.size();
      rb = resp_log.size();
      for (int k = 0; k < 3; k++)
         push_exp(bv[k]);
      drive(bv[0]);
      for (int k = 0; k < 3; k++) begin
         wait_accept();
         if (k < 2) drive(bv[k + 1]);
         else idle_req();
      end
      wait_done();
      check("b2b_accepts", acc_log.size() - ab, 32'h3);
      if (acc_log.size() >= ab + 3 && resp_log.size() >= rb + 3) begin
         for (int k = 1; k < 3; k++)
            check("b2b_gap", acc_log[ab + k] - resp_log[rb + k - 1],
                  32'h2);
      end else begin
         check("b2b_logs", resp_log.size() - rb, 32'h3);
      end

      // reset asserted while a byte store sits in DATA
      bd_write(8, 32'h55667788);
      wc = we_cnt;
      v = '{1, 2'b00, 0, 32'h21, 32'h00000099, 32'h0, 0, 0};
      drive(v);
      wait_accept();
      idle_req();
      @(posedge clock);
      #1;
      check("data_addr", ram_address, 32'h20);
      reset_n = 1'b0;
      #1;
      check_reset("abort");
      repeat (2) @(posedge clock);
      #1;
      check("abort_mem", mem[8], 32'h55667788);
      check("abort_we", we_cnt - wc, 32'h0);
      reset_n = 1'b1;
      acc_q.delete();
      @(negedge clock);
      check("abort_ready", {31'h0, bus.req_ready}, 32'h1);
      @(posedge clock);
      #1;
      v = '{0, 2'b10, 0, 32'h20, 32'h0, 32'h55667788, 0, 3};
      run_vec(v);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
